// File: rtl/ofs1p3_serializer.sv
// ofs1p3_serializer: parallel-to-serial output register with valid/ready intake,
// clock-enabled serial flop on Q/OE and a one-cycle DONE pulse at stream end.
module ofs1p3_serializer #(
    parameter int    WIDTH     = 8,
    parameter int    LSB_FIRST = 1,
    parameter string REGSET    = "RESET"
) (
    input  logic             CLK,
    input  logic             LSR,
    input  logic             SP,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             Q,
    output logic             OE,
    output logic             DONE
);
    localparam int   CW     = $clog2(WIDTH);
    localparam logic IDLE_Q = (REGSET == "SET");

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-2:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             q_n, oe_n, done_n;
    logic             accept;

    assign READY  = (state == IDLE) || (cnt == '0);
    assign accept = READY && VALID && SP;

    always_ff @(posedge CLK or posedge LSR) begin
        if (LSR) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            Q     <= IDLE_Q;
            OE    <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            Q     <= q_n;
            OE    <= oe_n;
            DONE  <= done_n;
        end
    end

    // sr always holds the remaining bits in shift order; a new word may load
    // straight over the last bit so streams run without an idle gap.
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        q_n     = Q;
        oe_n    = OE;
        done_n  = 1'b0;
        if (accept) begin
            state_n = SHIFT;
            q_n     = LSB_FIRST ? DATA[0] : DATA[WIDTH-1];
            sr_n    = LSB_FIRST ? DATA[WIDTH-1:1] : DATA[WIDTH-2:0];
            cnt_n   = CW'(WIDTH - 1);
            oe_n    = 1'b1;
        end else if (SP && state == SHIFT && cnt != '0) begin
            q_n   = LSB_FIRST ? sr[0] : sr[WIDTH-2];
            sr_n  = LSB_FIRST ? sr >> 1 : sr << 1;
            cnt_n = cnt - 1'b1;
        end else if (SP && state == SHIFT) begin
            state_n = IDLE;
            q_n     = IDLE_Q;
            oe_n    = 1'b0;
            done_n  = 1'b1;
        end
    end
endmodule

// File: tb/tb_ofs1p3_serializer.sv
// tb_ofs1p3_serializer: directed checks of an LSB-first/RESET instance and an
// MSB-first/SET instance driven from the same stimulus.
module tb_ofs1p3_serializer;
    logic       clk = 1'b0;
    logic       lsr = 1'b1;
    logic       sp = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready_l, q_l, oe_l, done_l;
    logic       ready_m, q_m, oe_m, done_m;
    logic [7:0] seq;
    logic [15:0] seq16;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ofs1p3_serializer #(.WIDTH(8), .LSB_FIRST(1), .REGSET("RESET")) dut_l (
        .CLK(clk), .LSR(lsr), .SP(sp), .DATA(data), .VALID(valid),
        .READY(ready_l), .Q(q_l), .OE(oe_l), .DONE(done_l)
    );

    ofs1p3_serializer #(.WIDTH(8), .LSB_FIRST(0), .REGSET("SET")) dut_m (
        .CLK(clk), .LSR(lsr), .SP(sp), .DATA(data), .VALID(valid),
        .READY(ready_m), .Q(q_m), .OE(oe_m), .DONE(done_m)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sp = 1'b1;
        repeat (2) tick;
        check("rst_q_l", q_l, 1'b0);
        check("rst_q_m", q_m, 1'b1);
        lsr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle_q_l", q_l, 1'b0);
            check("idle_q_m", q_m, 1'b1);
            check("idle_oe", oe_l, 1'b0);
            check("idle_done", done_l, 1'b0);
            check("idle_ready", ready_l, 1'b1);
        end

        data = 8'hA5;
        valid = 1'b1;
        seq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            tick;
            valid = 1'b0;
            check("a5_q", q_l, seq[7-i]);
            check("a5_oe", oe_l, 1'b1);
            check("a5_ready", ready_l, i == 7);
            check("a5_done", done_l, 1'b0);
        end
        tick;
        check("a5_end_q", q_l, 1'b0);
        check("a5_end_oe", oe_l, 1'b0);
        check("a5_end_done", done_l, 1'b1);
        tick;
        check("a5_done_clr", done_l, 1'b0);

        data = 8'hF0;
        valid = 1'b1;
        seq16 = 16'b1111_0000_0000_1111;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (i == 0) data = 8'h0F;
            if (i == 8) valid = 1'b0;
            check("b2b_q", q_m, seq16[15-i]);
            check("b2b_oe", oe_m, 1'b1);
            check("b2b_done", done_m, 1'b0);
        end
        tick;
        check("b2b_end_q", q_m, 1'b1);
        check("b2b_end_oe", oe_m, 1'b0);
        check("b2b_end_done", done_m, 1'b1);
        tick;
        check("b2b_done_clr", done_m, 1'b0);

        data = 8'h81;
        valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            sp = !(i >= 2 && i <= 4);
            tick;
            valid = 1'b0;
            check("sp_q", q_l, i == 0 || i == 10);
            check("sp_oe", oe_l, 1'b1);
            check("sp_ready", ready_l, i == 10);
            check("sp_done", done_l, 1'b0);
        end
        sp = 1'b1;
        tick;
        check("sp_end_oe", oe_l, 1'b0);
        check("sp_end_done", done_l, 1'b1);

        sp = 1'b0;
        valid = 1'b1;
        data = 8'hFF;
        tick;
        check("spoff_oe", oe_l, 1'b0);
        check("spoff_q", q_l, 1'b0);
        check("spoff_done_clr", done_l, 1'b0);
        valid = 1'b0;
        sp = 1'b1;
        tick;
        check("spoff_no_accept_oe", oe_l, 1'b0);
        check("spoff_no_accept_q", q_l, 1'b0);

        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            valid = 1'b0;
        end
        check("abort_pre_q", q_l, 1'b1);
        check("abort_pre_oe", oe_l, 1'b1);
        #2 lsr = 1'b1;
        #1;
        check("abort_q_l", q_l, 1'b0);
        check("abort_q_m", q_m, 1'b1);
        check("abort_oe", oe_l, 1'b0);
        check("abort_ready", ready_l, 1'b1);
        tick;
        lsr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("abort_no_done", done_l, 1'b0);
            check("abort_oe_low", oe_l, 1'b0);
        end

        data = 8'h3C;
        valid = 1'b1;
        seq = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            tick;
            valid = 1'b0;
            check("3c_q", q_l, seq[7-i]);
            check("3c_oe", oe_l, 1'b1);
        end
        tick;
        check("3c_end_q", q_l, 1'b0);
        check("3c_end_done", done_l, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofs1p3_serializer.md
# ofs1p3_serializer

Parallel-to-serial output register for ECP5 I/O paths. It is the transmit-side counterpart of the `IFS1P3*` input-register capture path. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock on a registered pin-side output `Q`, with a matching registered output enable. The serial stage maps onto an `OFS1P3DX`/`OFS1P3BX`-style output flop (clock enable `SP`, asynchronous `LSR`, programmable reset level). Back-to-back words stream with no idle gap.

## Interface
Parameters:
- `WIDTH`, 8: bits per word. Legal range is ≥2.
- `LSB_FIRST`, 1: 1 shifts bit 0 out first; 0 shifts bit WIDTH-1 out first.
- `REGSET`, "RESET": idle/reset level of `Q`. "RESET" gives 0, "SET" gives 1.

Ports:
- `CLK`  in  1: clock; all state updates on the rising edge.
- `LSR`  in  1: reset, asynchronous, active-high.
- `SP`  in  1: clock enable. When low, all state holds (`DONE` excepted).
- `DATA`  in  WIDTH: parallel word. Sampled only on an accept edge.
- `VALID`  in  1: `DATA` is offered.
- `READY`  out  1: block can accept a word on this edge. Combinational from state.
- `Q`  out  1: registered serial output.
- `OE`  out  1: registered output enable. High while a word is on `Q`.
- `DONE`  out  1: registered one-cycle pulse when the stream ends.

## Operation
- Registers:
  - state: IDLE or SHIFT.
  - `sr`: WIDTH-1 bit shift register.
  - `cnt`: remaining-bit counter, width $clog2(WIDTH).
  - `Q`, `OE`, `DONE`.
- Values while `LSR` is asserted: state=IDLE, `Q`=idle level, `OE`=0, `DONE`=0, `cnt`=0, `sr`=0.
- `READY` = (state==IDLE) or (state==SHIFT and `cnt`==0). It is therefore 1 immediately after reset.
- Accept = `READY` & `VALID` & `SP` at a rising edge. On an accept edge:
  - `Q` ← first bit (`DATA[0]` if `LSB_FIRST`, else `DATA[WIDTH-1]`).
  - `sr` ← remaining WIDTH-1 bits in shift order.
  - `cnt` ← WIDTH-1; `OE` ← 1; state ← SHIFT.
- SHIFT with `SP`=1 and `cnt`≠0: `Q` ← next bit from `sr`, `sr` shifts by one, `cnt` ← `cnt`-1.
- SHIFT with `SP`=1 and `cnt`==0 (last bit currently on `Q`):
  - If `VALID`=1: accept the new word as above. `Q` moves directly to its first bit; `OE` stays 1; `DONE` is not pulsed.
  - If `VALID`=0: state ← IDLE, `Q` ← idle level, `OE` ← 0, `DONE` ← 1.
- IDLE with no accept: `Q` holds the idle level and `OE` stays 0.
- `SP`=0: `Q`, `OE`, `sr`, `cnt` and state hold. No accept occurs even if `READY` & `VALID`. `DONE` ← 0.
- `DONE` ← 0 on every edge except the SHIFT→IDLE edge.
- `DATA` changes after the accept edge have no effect on the word in flight.
- `LSR` asserted mid-word aborts the word immediately, without waiting for a clock edge. The rest of the word is discarded and no `DONE` pulse is produced.

## Timing
- Latency: first bit appears on `Q` at the accept edge itself (registered output, zero extra pipeline).
- Each bit occupies `Q` for exactly one `SP`-enabled cycle. A word spans WIDTH enabled cycles.
- Throughput: one word per WIDTH enabled cycles when `VALID` is held high.
- `READY` is high in the last-bit cycle of a word, so a source that keeps `VALID` up streams gap-free.
- `OE` rises on the same edge as the first bit and falls on the same edge `Q` returns to the idle level.
- `DONE` is high for one `CLK` cycle, in the cycle after the last bit.
- `LSR` is asynchronous. Release must be synchronous to `CLK` at the system level. The first accept is possible on the first edge after release.

## Test plan
- Reset values, `REGSET`="RESET" and "SET": assert `LSR`, then release with `VALID`=0 -> `Q`=0 (resp. 1), `OE`=0, `DONE`=0, `READY`=1, all stable over 10 cycles.
- Single word, WIDTH=8, `LSB_FIRST`=1, `DATA`=0xA5, `SP`=1 -> `Q` = 1,0,1,0,0,1,0,1 on 8 consecutive edges starting at the accept edge.
  - `OE`=1 for those 8 cycles.
  - `READY`=0 for cycles 1–7 and 1 in cycle 8.
  - Then `Q`=0, `OE`=0, `DONE`=1 for exactly one cycle.
- Back-to-back words, `LSB_FIRST`=0, `VALID` held high with 0xF0 then 0x0F -> `Q` = 1111000000001111 over 16 edges.
  - `OE` stays high throughout and `DONE` pulses only after bit 16.
- `SP` gating: `DATA`=0x81, `LSB_FIRST`=1, `SP` low for 3 cycles after bit 2 -> `Q` holds bit 2 for 4 cycles, `cnt` frozen, and the word completes 3 cycles late with the correct sequence.
  - A `VALID` pulse with `SP`=0 while IDLE is not accepted.
- Abort: assert `LSR` asynchronously between edges during bit 4 of 0xFF -> `Q`=idle level and `OE`=0 immediately, no `DONE`.
  - After release, the next word (0x3C) shifts out correctly from bit 0.
